lock_monitor: RTL and testbench

//   Parametrised NCH-channel successor to the single-PLL lock-state logic. Runs on refclk.

---
 rtl/lock_monitor_if.sv | 37 +++
 rtl/lock_monitor.sv | 184 ++++++++++++++++++
 tb/tb_lock_monitor.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lock_monitor_if.sv
// Sample/status bundle between the PLL error detectors, system control and lock_monitor.
// unlock_events exists only when LOCK_MONITOR_STATS_EN is defined.
interface lock_monitor_if #(
  parameter int NCH = 4,
  parameter int EW  = 8
);
  logic [NCH-1:0]    clear;
  logic [NCH-1:0]    err_valid;
  logic [NCH*EW-1:0] freq_err;
  logic [NCH*EW-1:0] phase_err;
  logic [NCH*2-1:0]  lock_state;
  logic [NCH-1:0]    locked;
  logic [NCH-1:0]    fault;
  logic              all_locked;
  logic              any_fault;
`ifdef LOCK_MONITOR_STATS_EN
  logic [NCH*16-1:0] unlock_events;

  modport master (
    output clear, err_valid, freq_err, phase_err,
    input  lock_state, locked, fault, all_locked, any_fault, unlock_events
  );
  modport slave (
    input  clear, err_valid, freq_err, phase_err,
    output lock_state, locked, fault, all_locked, any_fault, unlock_events
  );
`else
  modport master (
    output clear, err_valid, freq_err, phase_err,
    input  lock_state, locked, fault, all_locked, any_fault
  );
  modport slave (
    input  clear, err_valid, freq_err, phase_err,
    output lock_state, locked, fault, all_locked, any_fault
  );
`endif
endinterface

// File: rtl/lock_monitor.sv
// NCH-channel PLL lock monitor: per-channel lock FSM with hysteresis, lock timeout, aggregate flags.
// Define LOCK_MONITOR_STATS_EN to add per-channel saturating unlock_events counters.
module lock_monitor #(
  parameter int NCH        = 4,
  parameter int EW         = 8,
  parameter int FREQ_TOL   = 4,
  parameter int PHASE_TOL  = 1,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int TIMEOUT    = 1250
) (
  input  logic          refclk,
  input  logic          reset,
  lock_monitor_if.slave bus
);
  localparam int CMAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_FREQ     = 2'd1;
  localparam logic [1:0] ST_PHASE    = 2'd2;
  localparam logic [1:0] ST_FAULT    = 2'd3;

  localparam logic [CW-1:0] LOCK_LIM   = CW'(LOCK_CNT);
  localparam logic [CW-1:0] UNLOCK_LIM = CW'(UNLOCK_CNT);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [EW:0]   FREQ_LIM   = (EW+1)'(FREQ_TOL);
  localparam logic [EW:0]   PHASE_LIM  = (EW+1)'(PHASE_TOL);

  // One extra bit so the most negative sample maps to a large magnitude
  function automatic logic [EW:0] abs_ext(input logic signed [EW-1:0] x);
    logic signed [EW:0] w;
    w = {x[EW-1], x};
    return x[EW-1] ? $unsigned(-w) : $unsigned(w);
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  logic [1:0]    st_q   [NCH];
  logic [1:0]    st_d   [NCH];
  logic [CW-1:0] good_q [NCH];
  logic [CW-1:0] good_d [NCH];
  logic [CW-1:0] bad_q  [NCH];
  logic [CW-1:0] bad_d  [NCH];
  logic [TW-1:0] to_q   [NCH];
  logic [TW-1:0] to_d   [NCH];
  logic [CW-1:0] good_inc [NCH];
  logic [CW-1:0] bad_inc  [NCH];
  logic [NCH-1:0] fgood, pgood;
  logic [NCH-1:0] locked_q, locked_d, fault_q, fault_d;
  logic           all_locked_q, all_locked_d, any_fault_q, any_fault_d;
`ifdef LOCK_MONITOR_STATS_EN
  logic [NCH-1:0] exit_phase;
  logic [15:0]    unl_q [NCH];
  logic [15:0]    unl_d [NCH];
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_qual
    assign fgood[g]    = abs_ext(bus.freq_err[g*EW +: EW]) <= FREQ_LIM;
    assign pgood[g]    = fgood[g] && (abs_ext(bus.phase_err[g*EW +: EW]) <= PHASE_LIM);
    assign good_inc[g] = sat_inc(good_q[g]);
    assign bad_inc[g]  = sat_inc(bad_q[g]);
    assign bus.lock_state[2*g +: 2] = st_q[g];
`ifdef LOCK_MONITOR_STATS_EN
    assign bus.unlock_events[16*g +: 16] = unl_q[g];
`endif
  end

  always_comb begin
`ifdef LOCK_MONITOR_STATS_EN
    exit_phase = '0;
`endif
    for (int i = 0; i < NCH; i++) begin
      st_d[i]   = st_q[i];
      good_d[i] = good_q[i];
      bad_d[i]  = bad_q[i];
      to_d[i]   = to_q[i];
      if (bus.clear[i]) begin
        st_d[i]   = ST_UNLOCKED;
        good_d[i] = '0;
        bad_d[i]  = '0;
        to_d[i]   = '0;
      end else begin
        case (st_q[i])
          ST_UNLOCKED: begin
            to_d[i] = to_q[i] + 1'b1;
            if (bus.err_valid[i]) good_d[i] = fgood[i] ? good_inc[i] : '0;
            if (to_q[i] == TO_LAST) begin
              st_d[i] = ST_FAULT; good_d[i] = '0; bad_d[i] = '0; to_d[i] = '0;
            end else if (bus.err_valid[i] && fgood[i] && good_inc[i] >= LOCK_LIM) begin
              st_d[i] = ST_FREQ; good_d[i] = '0; bad_d[i] = '0;
            end
          end
          ST_FREQ: begin
            to_d[i] = to_q[i] + 1'b1;
            if (bus.err_valid[i]) begin
              good_d[i] = pgood[i] ? good_inc[i] : '0;
              bad_d[i]  = fgood[i] ? '0 : bad_inc[i];
            end
            // Promotion outranks a coincident timeout
            if (bus.err_valid[i] && pgood[i] && good_inc[i] >= LOCK_LIM) begin
              st_d[i] = ST_PHASE; good_d[i] = '0; bad_d[i] = '0; to_d[i] = '0;
            end else if (to_q[i] == TO_LAST) begin
              st_d[i] = ST_FAULT; good_d[i] = '0; bad_d[i] = '0; to_d[i] = '0;
            end else if (bus.err_valid[i] && !fgood[i] && bad_inc[i] >= UNLOCK_LIM) begin
              st_d[i] = ST_UNLOCKED; good_d[i] = '0; bad_d[i] = '0;
            end
          end
          ST_PHASE: begin
            to_d[i]   = '0;
            good_d[i] = '0;
            if (bus.err_valid[i]) bad_d[i] = pgood[i] ? '0 : bad_inc[i];
            if (bus.err_valid[i] && !pgood[i] && bad_inc[i] >= UNLOCK_LIM) begin
              st_d[i]  = fgood[i] ? ST_FREQ : ST_UNLOCKED;
              bad_d[i] = '0;
`ifdef LOCK_MONITOR_STATS_EN
              exit_phase[i] = 1'b1;
`endif
            end
          end
          default: begin
            good_d[i] = '0;
            bad_d[i]  = '0;
            to_d[i]   = '0;
          end
        endcase
      end
      locked_d[i] = (st_d[i] == ST_PHASE);
      fault_d[i]  = (st_d[i] == ST_FAULT);
    end
    all_locked_d = &locked_d;
    any_fault_d  = |fault_d;
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]   <= ST_UNLOCKED;
        good_q[i] <= '0;
        bad_q[i]  <= '0;
        to_q[i]   <= '0;
      end
      locked_q     <= '0;
      fault_q      <= '0;
      all_locked_q <= 1'b0;
      any_fault_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]   <= st_d[i];
        good_q[i] <= good_d[i];
        bad_q[i]  <= bad_d[i];
        to_q[i]   <= to_d[i];
      end
      locked_q     <= locked_d;
      fault_q      <= fault_d;
      all_locked_q <= all_locked_d;
      any_fault_q  <= any_fault_d;
    end
  end

  assign bus.locked     = locked_q;
  assign bus.fault      = fault_q;
  assign bus.all_locked = all_locked_q;
  assign bus.any_fault  = any_fault_q;

`ifdef LOCK_MONITOR_STATS_EN
  // Only sample-driven demotions count; clear and reset are not unlock events
  always_comb begin
    for (int i = 0; i < NCH; i++)
      unl_d[i] = (exit_phase[i] && unl_q[i] != 16'hFFFF) ? unl_q[i] + 16'd1 : unl_q[i];
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) unl_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) unl_q[i] <= unl_d[i];
    end
  end
`endif
endmodule

// File: tb/tb_lock_monitor.sv
// Bench for lock_monitor: directed table of multi-sample vectors, corner sequences, and a
// randomized run compared against a time-stamp based reference model.
module tb_lock_monitor;
  localparam int NCH        = 4;
  localparam int EW         = 8;
  localparam int FREQ_TOL   = 4;
  localparam int PHASE_TOL  = 1;
  localparam int LOCK_CNT   = 16;
  localparam int UNLOCK_CNT = 4;
  localparam int TIMEOUT    = 1250;
  localparam int S_UNL = 0, S_FRQ = 1, S_PHL = 2, S_FLT = 3;
  localparam int NV = 18;

  logic refclk = 1'b0;
  logic reset;
  always #5 refclk = ~refclk;

  lock_monitor_if #(.NCH(NCH), .EW(EW)) bus ();

  lock_monitor #(
    .NCH(NCH), .EW(EW), .FREQ_TOL(FREQ_TOL), .PHASE_TOL(PHASE_TOL),
    .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .refclk(refclk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int ch;
    int n;
    int fe;
    int pe;
    int exp_st;
  } vec_t;

  vec_t vecs [NV];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: state per channel, consecutive good/bad runs, and the edge at which the
  // channel last started accumulating time outside PHASE_LOCKED.
  int m_st [NCH], m_good [NCH], m_bad [NCH], m_since [NCH], m_unl [NCH];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_step(input logic rst_i, input logic [NCH-1:0] clr, input logic [NCH-1:0] vld,
                            input logic [NCH*EW-1:0] fev, input logic [NCH*EW-1:0] pev);
    for (int c = 0; c < NCH; c++) begin
      logic signed [EW-1:0] fs, ps;
      int  fe, pe, g, b;
      bit  fg, pg, promote, up, down;
      fs = fev[c*EW +: EW];
      ps = pev[c*EW +: EW];
      fe = int'(fs);
      pe = int'(ps);
      fg = iabs(fe) <= FREQ_TOL;
      pg = fg && (iabs(pe) <= PHASE_TOL);
      if (rst_i) begin
        m_st[c] = S_UNL; m_good[c] = 0; m_bad[c] = 0; m_since[c] = cyc; m_unl[c] = 0;
      end else if (clr[c]) begin
        m_st[c] = S_UNL; m_good[c] = 0; m_bad[c] = 0; m_since[c] = cyc;
      end else if (m_st[c] == S_PHL) begin
        m_since[c] = cyc;
        if (vld[c]) begin
          m_bad[c] = pg ? 0 : m_bad[c] + 1;
          if (m_bad[c] >= UNLOCK_CNT) begin
            m_st[c]  = fg ? S_FRQ : S_UNL;
            m_bad[c] = 0;
            if (m_unl[c] < 65535) m_unl[c]++;
          end
        end
      end else if (m_st[c] != S_FLT) begin
        g = m_good[c]; b = m_bad[c];
        promote = 0; up = 0; down = 0;
        if (vld[c]) begin
          if (m_st[c] == S_UNL) begin
            g  = fg ? g + 1 : 0;
            up = g >= LOCK_CNT;
          end else begin
            g       = pg ? g + 1 : 0;
            b       = fg ? 0 : b + 1;
            promote = g >= LOCK_CNT;
            down    = b >= UNLOCK_CNT;
          end
        end
        if (promote)                          begin m_st[c] = S_PHL; g = 0; b = 0; end
        else if (cyc - m_since[c] >= TIMEOUT) begin m_st[c] = S_FLT; g = 0; b = 0; end
        else if (up)                          begin m_st[c] = S_FRQ; g = 0; b = 0; end
        else if (down)                        begin m_st[c] = S_UNL; g = 0; b = 0; end
        m_good[c] = g;
        m_bad[c]  = b;
      end
    end
  endtask

  task automatic step(input logic rst_i, input logic [NCH-1:0] clr, input logic [NCH-1:0] vld,
                      input logic [NCH*EW-1:0] fev, input logic [NCH*EW-1:0] pev);
    reset         = rst_i;
    bus.clear     = clr;
    bus.err_valid = vld;
    bus.freq_err  = fev;
    bus.phase_err = pev;
    @(posedge refclk);
    #1;
    cyc++;
    model_step(rst_i, clr, vld, fev, pev);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    repeat (n) step(1'b1, '0, '0, '0, '0);
  endtask

  task automatic samp(input int ch, input int fe, input int pe, input logic clr);
    logic [NCH*EW-1:0] fv, pv;
    logic [NCH-1:0]    v, cl;
    fv = '0; pv = '0; v = '0; cl = '0;
    fv[ch*EW +: EW] = EW'(fe);
    pv[ch*EW +: EW] = EW'(pe);
    v[ch]  = 1'b1;
    cl[ch] = clr;
    step(1'b0, cl, v, fv, pv);
  endtask

  function automatic int st_of(input int ch);
    return int'(bus.lock_state[2*ch +: 2]);
  endfunction

  task automatic check_model();
    logic [NCH*2-1:0] es;
    logic [NCH-1:0]   el, ef;
    for (int c = 0; c < NCH; c++) begin
      es[2*c +: 2] = 2'(m_st[c]);
      el[c] = (m_st[c] == S_PHL);
      ef[c] = (m_st[c] == S_FLT);
    end
    check("rand lock_state", int'(bus.lock_state), int'(es));
    check("rand locked",     int'(bus.locked),     int'(el));
    check("rand fault",      int'(bus.fault),      int'(ef));
    check("rand all_locked", int'(bus.all_locked), int'(&el));
    check("rand any_fault",  int'(bus.any_fault),  int'(|ef));
`ifdef LOCK_MONITOR_STATS_EN
    for (int c = 0; c < NCH; c++)
      check($sformatf("rand unlock_events[%0d]", c), int'(bus.unlock_events[16*c +: 16]), m_unl[c]);
`endif
  endtask

  initial begin
    int tbl_rst;
    int guard;

    // Reset state, then idle timeout of every channel
    do_reset(5);
    check("reset lock_state", int'(bus.lock_state), 0);
    check("reset locked",     int'(bus.locked),     0);
    check("reset fault",      int'(bus.fault),      0);
    check("reset all_locked", int'(bus.all_locked), 0);
    check("reset any_fault",  int'(bus.any_fault),  0);
    idle(TIMEOUT - 1);
    check("pre-timeout lock_state", int'(bus.lock_state), 0);
    check("pre-timeout any_fault",  int'(bus.any_fault),  0);
    idle(1);
    check("timeout lock_state", int'(bus.lock_state), 255);
    check("timeout fault",      int'(bus.fault),      15);
    check("timeout any_fault",  int'(bus.any_fault),  1);
    check("timeout locked",     int'(bus.locked),     0);

    // Channel 0 lock / hysteresis / tolerance-boundary table
    do_reset(2);
    tbl_rst = cyc;
    vecs = '{
      '{0, 15,    3,  0, S_UNL},
      '{0,  1,    3,  0, S_FRQ},
      '{0, 15,    0,  1, S_FRQ},
      '{0,  1,    0,  1, S_PHL},
      '{0,  3,    0,  5, S_PHL},
      '{0,  1,    0,  0, S_PHL},
      '{0,  3,    0,  5, S_PHL},
      '{0,  1,    0,  5, S_FRQ},
      '{0, 16,    0, -1, S_PHL},
      '{0,  3,    0,  5, S_PHL},
      '{0,  1, -128,  5, S_UNL},
      '{0, 16, -128,  0, S_UNL},
      '{0, 16,   -4,  0, S_FRQ},
      '{0,  3,    9,  0, S_FRQ},
      '{0,  1,    9,  0, S_UNL},
      '{0, 16,    4,  0, S_FRQ},
      '{0, 16,    0,  2, S_FRQ},
      '{0, 16,    0, -1, S_PHL}
    };
    for (int k = 0; k < NV; k++) begin
      repeat (vecs[k].n) samp(vecs[k].ch, vecs[k].fe, vecs[k].pe, 1'b0);
      check($sformatf("vec%0d lock_state", k), st_of(vecs[k].ch), vecs[k].exp_st);
      check($sformatf("vec%0d locked", k), int'(bus.locked[vecs[k].ch]),
            (vecs[k].exp_st == S_PHL) ? 1 : 0);
    end
    check("all_locked with idle channels", int'(bus.all_locked), 0);

    // Idle channels time out; channel 0 stays locked
    guard = 0;
    while (!bus.fault[2] && guard < 2 * TIMEOUT) begin
      idle(1);
      guard++;
    end
    check("ch2 timeout edge", cyc - tbl_rst, TIMEOUT);
    check("ch0 still locked", st_of(0), S_PHL);
    check("ch1 faulted", st_of(1), S_FLT);

    // Clear together with a valid sample on a faulted channel
    samp(2, 0, 0, 1'b1);
    check("ch2 after clear", st_of(2), S_UNL);
    check("ch1 undisturbed", st_of(1), S_FLT);
    check("ch3 undisturbed", st_of(3), S_FLT);
    check("ch0 undisturbed", st_of(0), S_PHL);
    check("fault after clear", int'(bus.fault), 10);
    check("any_fault after clear", int'(bus.any_fault), 1);

    // Clear mid-count wins over the sample that would otherwise promote
    repeat (LOCK_CNT - 1) samp(2, 0, 0, 1'b0);
    check("ch2 mid-count", st_of(2), S_UNL);
    samp(2, 0, 0, 1'b1);
    check("ch2 clear beats promotion", st_of(2), S_UNL);
    repeat (LOCK_CNT - 1) samp(2, 0, 0, 1'b0);
    check("ch2 count restarted", st_of(2), S_UNL);
    samp(2, 0, 0, 1'b0);
    check("ch2 freq locked", st_of(2), S_FRQ);

    // Randomized run against the reference model
    do_reset(2);
    for (int seg = 0; seg < 30; seg++) begin
      int noise [NCH];
      for (int c = 0; c < NCH; c++) begin
        case ($urandom_range(0, 3))
          0:       noise[c] = 0;
          1:       noise[c] = 3;
          2:       noise[c] = 25;
          default: noise[c] = 60;
        endcase
      end
      for (int t = 0; t < 100; t++) begin
        logic [NCH*EW-1:0] fv, pv;
        logic [NCH-1:0]    v, cl;
        int fe, pe;
        for (int c = 0; c < NCH; c++) begin
          v[c]  = ($urandom_range(0, 9) != 0);
          cl[c] = ($urandom_range(0, 499) == 0);
          if (int'($urandom_range(0, 99)) < noise[c]) begin
            fe = int'($urandom_range(0, 255)) - 128;
            pe = int'($urandom_range(0, 255)) - 128;
          end else begin
            fe = int'($urandom_range(0, 8)) - 4;
            pe = int'($urandom_range(0, 2)) - 1;
          end
          fv[c*EW +: EW] = EW'(fe);
          pv[c*EW +: EW] = EW'(pe);
        end
        step(1'b0, cl, v, fv, pv);
        check_model();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
